// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame settings in, byte and status out.
// master = the side driving the line and settings, slave = the receiver.
interface uart_rx_if;
    logic        rxd;
    logic [15:0] baud_max_cnt;
    logic [1:0]  parity_sel;
    logic        stop_sel;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        rx_busy;

    modport master (
        output rxd, baud_max_cnt, parity_sel, stop_sel,
        input  rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

    modport slave (
        input  rxd, baud_max_cnt, parity_sel, stop_sel,
        output rx_data, rx_valid, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver with runtime frame format (period, parity, 1/2 stop bits).
// Samples each bit at mid-period and reports one byte per frame with
// parity and framing status.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the parity bit (odd/even modes only)
// STOP1  | sampling the first stop bit
// STOP2  | sampling the second stop bit (two-stop mode only)
// DONE   | outputs loaded, rx_valid high for this one cycle
module uart_rx (
    input  logic     clock,
    input  logic     reset,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

    state_t      state;
    logic        rxs_meta;
    logic        rxs;
    logic        rxs_d;
    logic [15:0] cnt;
    logic [15:0] baud_lim;
    logic [15:0] half_lim;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        perr_pend;
    logic        ferr_pend;
    logic        parity_on;
    logic        full_tick;
    logic        half_tick;

    // Period limits; >= compares keep the FSM moving if settings change mid-frame.
    always_comb begin
        baud_lim  = (bus.baud_max_cnt < 16'd3) ? 16'd3 : bus.baud_max_cnt;
        half_lim  = {1'b0, baud_lim[15:1]};
        full_tick = (cnt >= baud_lim);
        half_tick = (cnt >= half_lim);
        parity_on = (bus.parity_sel == 2'b01) || (bus.parity_sel == 2'b10);
    end

    // Two-flop synchroniser plus one delay flop for falling-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxs_meta <= 1'b1;
            rxs      <= 1'b1;
            rxs_d    <= 1'b1;
        end else begin
            rxs_meta <= bus.rxd;
            rxs      <= rxs_meta;
            rxs_d    <= rxs;
        end
    end

    // Frame FSM with bit timer, shift register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 16'd0;
            idx            <= 3'd0;
            shift          <= 8'h00;
            perr_pend      <= 1'b0;
            ferr_pend      <= 1'b0;
            bus.rx_data    <= 8'h00;
            bus.rx_valid   <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.rx_busy    <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    if (rxs_d && !rxs) begin
                        state       <= START;
                        bus.rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (half_tick) begin
                        cnt <= 16'd0;
                        if (rxs) begin
                            // line back high at mid start bit: glitch
                            state       <= IDLE;
                            bus.rx_busy <= 1'b0;
                        end else begin
                            idx       <= 3'd0;
                            perr_pend <= 1'b0;
                            ferr_pend <= 1'b0;
                            state     <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (full_tick) begin
                        cnt        <= 16'd0;
                        shift[idx] <= rxs;
                        if (idx == 3'd7) begin
                            state <= parity_on ? PARITY : STOP1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (full_tick) begin
                        cnt <= 16'd0;
                        if (bus.parity_sel == 2'b01) begin
                            perr_pend <= ~(^shift ^ rxs);
                        end else begin
                            perr_pend <= ^shift ^ rxs;
                        end
                        state <= STOP1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP1: begin
                    if (full_tick) begin
                        cnt <= 16'd0;
                        if (bus.stop_sel) begin
                            ferr_pend <= !rxs;
                            state     <= STOP2;
                        end else begin
                            bus.rx_data    <= shift;
                            bus.parity_err <= perr_pend;
                            bus.frame_err  <= !rxs;
                            bus.rx_valid   <= 1'b1;
                            state          <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP2: begin
                    if (full_tick) begin
                        cnt            <= 16'd0;
                        bus.rx_data    <= shift;
                        bus.parity_err <= perr_pend;
                        bus.frame_err  <= ferr_pend | !rxs;
                        bus.rx_valid   <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    bus.rx_busy <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    bus.rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
